// File: rtl/round_key_store.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : round_key_store
// Description : Buffers expanded AES round keys and streams them to the round
//               pipeline in forward (encrypt) or reverse (decrypt) order.
//               Optional macro ROUND_KEY_STORE_PREFETCH_EN adds a next-key
//               register so back-to-back acks return one key per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module round_key_store #(
    parameter int KEY_W  = 128,
    parameter int DEPTH  = 15,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              w_e,
    input  logic [ADDR_W-1:0] round_key_addr,
    input  logic [KEY_W-1:0]  round_key,
    input  logic              exp_done,
    input  logic [ADDR_W-1:0] rounds_total,
    input  logic              start,
    input  logic              decrypt,
    input  logic              key_ack,
    output logic [KEY_W-1:0]  key_o,
    output logic              key_valid_o,
    output logic [ADDR_W-1:0] key_idx_o,
    output logic              last_o,
    output logic              keys_ready,
    output logic              busy,
    output logic              wr_err,
    output logic              start_err
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [KEY_W-1:0]    r_mem [DEPTH];
    logic [KEY_W-1:0]    r_key;
    logic [ADDR_W-1:0]   r_rounds;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   r_end_idx;
    logic                r_dir;
    logic                r_keys_ready;
    logic                r_wr_err;
    logic                r_start_err;

    logic                w_idle;
    logic                w_wr_ok;
    logic                w_start_ok;
    logic                w_last;
    logic [ADDR_W-1:0]   w_idx_step;

    // Out-of-range slots read as zero; only reachable on discarded prefetches.
    function automatic logic [KEY_W-1:0] f_rd(input logic [ADDR_W-1:0] a);
        if ({1'b0, a} < c_depth) begin
            return r_mem[a];
        end
        return '0;
    endfunction

    assign w_idle     = (r_state == S_IDLE);
    assign w_wr_ok    = w_e && w_idle && ({1'b0, round_key_addr} < c_depth);
    assign w_start_ok = start && w_idle && r_keys_ready && ({1'b0, r_rounds} < c_depth);
    assign w_last     = (r_idx == r_end_idx);
    assign w_idx_step = r_dir ? (r_idx - ADDR_W'(1)) : (r_idx + ADDR_W'(1));

`ifdef ROUND_KEY_STORE_PREFETCH_EN
    logic [KEY_W-1:0]  r_next;
    logic [ADDR_W-1:0] w_idx_step2;
    assign w_idx_step2 = r_dir ? (w_idx_step - ADDR_W'(1)) : (w_idx_step + ADDR_W'(1));
`endif

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[round_key_addr] <= round_key;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_state_nxt = S_VALID;
            end
            S_VALID: begin
                if (key_ack) begin
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end else begin
`ifdef ROUND_KEY_STORE_PREFETCH_EN
                        w_state_nxt = S_VALID;
`else
                        w_state_nxt = S_READ;
`endif
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key        <= '0;
            r_rounds     <= '0;
            r_idx        <= '0;
            r_end_idx    <= '0;
            r_dir        <= 1'b0;
            r_keys_ready <= 1'b0;
            r_wr_err     <= 1'b0;
            r_start_err  <= 1'b0;
`ifdef ROUND_KEY_STORE_PREFETCH_EN
            r_next       <= '0;
`endif
        end else begin
            r_wr_err    <= w_e && !w_wr_ok;
            r_start_err <= start && !w_start_ok;

            // Completion beats a coincident write so the fresh set is usable.
            if (exp_done && w_idle) begin
                r_rounds     <= rounds_total;
                r_keys_ready <= 1'b1;
            end else if (w_wr_ok) begin
                r_keys_ready <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_dir     <= decrypt;
                        r_idx     <= decrypt ? r_rounds : '0;
                        r_end_idx <= decrypt ? '0 : r_rounds;
                    end
                end
                S_READ: begin
                    r_key <= f_rd(r_idx);
`ifdef ROUND_KEY_STORE_PREFETCH_EN
                    r_next <= f_rd(w_idx_step);
`endif
                end
                S_VALID: begin
                    if (key_ack && !w_last) begin
                        r_idx <= w_idx_step;
`ifdef ROUND_KEY_STORE_PREFETCH_EN
                        r_key  <= r_next;
                        r_next <= f_rd(w_idx_step2);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign key_o       = r_key;
    assign key_valid_o = (r_state == S_VALID);
    assign key_idx_o   = r_idx;
    assign last_o      = key_valid_o && w_last;
    assign keys_ready  = r_keys_ready;
    assign busy        = !w_idle;
    assign wr_err      = r_wr_err;
    assign start_err   = r_start_err;

endmodule
`default_nettype wire

// File: tb/tb_round_key_store.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_round_key_store
// Description : Scoreboard bench for round_key_store using FIPS-197 key sets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_round_key_store;

    localparam int KEY_W  = 128;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              w_e;
    logic [ADDR_W-1:0] round_key_addr;
    logic [KEY_W-1:0]  round_key;
    logic              exp_done;
    logic [ADDR_W-1:0] rounds_total;
    logic              start;
    logic              decrypt;
    logic              key_ack;
    logic [KEY_W-1:0]  key_o;
    logic              key_valid_o;
    logic [ADDR_W-1:0] key_idx_o;
    logic              last_o;
    logic              keys_ready;
    logic              busy;
    logic              wr_err;
    logic              start_err;

    round_key_store #(.KEY_W(KEY_W), .DEPTH(15), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .w_e            (w_e),
        .round_key_addr (round_key_addr),
        .round_key      (round_key),
        .exp_done       (exp_done),
        .rounds_total   (rounds_total),
        .start          (start),
        .decrypt        (decrypt),
        .key_ack        (key_ack),
        .key_o          (key_o),
        .key_valid_o    (key_valid_o),
        .key_idx_o      (key_idx_o),
        .last_o         (last_o),
        .keys_ready     (keys_ready),
        .busy           (busy),
        .wr_err         (wr_err),
        .start_err      (start_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [KEY_W-1:0]  key;
        logic [ADDR_W-1:0] idx;
        logic              last;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             mon_e;
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [KEY_W-1:0] k128 [11];
    logic [KEY_W-1:0] k256 [15];

    task automatic chk_k(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", name, act, req);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // Monitor: every handshake beat is checked against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && key_valid_o && key_ack) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL beat_unexpected: got idx %0d, want no beat", key_idx_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk_k("beat_key", key_o, mon_e.key);
                chk_i("beat_idx", int'(key_idx_o), int'(mon_e.idx));
                chk_b("beat_last", last_o, mon_e.last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [KEY_W-1:0] d,
                      input logic done, input logic [ADDR_W-1:0] nr);
        w_e = 1'b1; round_key_addr = a; round_key = d;
        exp_done = done; rounds_total = nr;
        tick();
        w_e = 1'b0; exp_done = 1'b0;
    endtask

    task automatic push_stream(input bit dec, input int nr, input bit big);
        exp_t t;
        int   ix;
        for (int i = 0; i <= nr; i++) begin
            ix     = dec ? (nr - i) : i;
            t.key  = big ? k256[ix] : k128[ix];
            t.idx  = 4'(ix);
            t.last = (i == nr);
            exp_q.push_back(t);
        end
    endtask

    task automatic do_start(input logic dec);
        start = 1'b1; decrypt = dec;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!key_valid_o && n < 10) begin
            tick();
            n++;
        end
        chk_b("wait_valid", key_valid_o, 1'b1);
    endtask

    task automatic ack_one();
        wait_valid();
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
    endtask

    // Full stream with ack held high; checks latency, beat count and span.
    task automatic run_acked(input logic dec, input int nkeys);
        int cyc = 0;
        int nv  = 0;
        int span;
`ifdef ROUND_KEY_STORE_PREFETCH_EN
        span = nkeys;
`else
        span = 2 * nkeys - 1;
`endif
        key_ack = 1'b1;
        do_start(dec);
        chk_b("lat_cycle1_valid", key_valid_o, 1'b0);
        chk_b("lat_cycle1_busy", busy, 1'b1);
        tick();
        chk_b("lat_cycle2_valid", key_valid_o, 1'b1);
        while (busy && cyc < 200) begin
            if (key_valid_o) nv++;
            cyc++;
            tick();
        end
        key_ack = 1'b0;
        chk_b("stream_end_busy", busy, 1'b0);
        chk_i("stream_valid_beats", nv, nkeys);
        chk_i("stream_span_cycles", cyc, span);
        chk_i("stream_queue_left", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        k128[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        k128[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        k128[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        k128[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        k128[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        k128[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        k128[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        k128[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        k128[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        k128[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        k128[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        k256[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        k256[1]  = 128'h101112131415161718191a1b1c1d1e1f;
        k256[2]  = 128'ha573c29fa176c498a97fce93a572c09c;
        k256[3]  = 128'h1651a8cd0244beda1a5da4c10640bade;
        k256[4]  = 128'hae87dff00ff11b68a68ed5fb03fc1567;
        k256[5]  = 128'h6de1f1486fa54f9275f8eb5373b8518d;
        k256[6]  = 128'hc656827fc9a799176f294cec6cd5598b;
        k256[7]  = 128'h3de23a75524775e727bf9eb45407cf39;
        k256[8]  = 128'h0bdc905fc27b0948ad5245a4c1871c2f;
        k256[9]  = 128'h45f5a66017b2d387300d4d33640a820a;
        k256[10] = 128'h7ccff71cbeb4fe5413e6bbf0d261a7df;
        k256[11] = 128'hf01afafee7a82979d7a5644ab3afe640;
        k256[12] = 128'h2541fe719bf500258813bbd55a721c0a;
        k256[13] = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
        k256[14] = 128'h24fc79ccbf0979e9371ac23c6d68de36;

        reset = 1'b1; w_e = 1'b0; round_key_addr = '0; round_key = '0;
        exp_done = 1'b0; rounds_total = '0; start = 1'b0; decrypt = 1'b0; key_ack = 1'b0;
        tick();
        tick();
        chk_k("rst_key_o", key_o, '0);
        chk_b("rst_key_valid", key_valid_o, 1'b0);
        chk_i("rst_key_idx", int'(key_idx_o), 0);
        chk_b("rst_last", last_o, 1'b0);
        chk_b("rst_keys_ready", keys_ready, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_wr_err", wr_err, 1'b0);
        chk_b("rst_start_err", start_err, 1'b0);
        reset = 1'b0;
        tick();

        // Start with no key set
        do_start(1'b0);
        chk_b("early_start_err", start_err, 1'b1);
        chk_b("early_start_busy", busy, 1'b0);
        tick();
        chk_b("early_start_err_clear", start_err, 1'b0);

        // Out-of-range write address
        wr(4'd15, '1, 1'b0, '0);
        chk_b("addr15_wr_err", wr_err, 1'b1);
        tick();
        chk_b("addr15_wr_err_clear", wr_err, 1'b0);

        // AES-128 load; last write coincides with exp_done
        for (int i = 0; i < 10; i++) wr(4'(i), k128[i], 1'b0, '0);
        wr(4'd10, k128[10], 1'b1, 4'd10);
        chk_b("aes128_keys_ready", keys_ready, 1'b1);
        push_stream(1'b0, 10, 1'b0);
        run_acked(1'b0, 11);
        chk_b("aes128_ready_kept", keys_ready, 1'b1);

        // AES-256 load then reverse stream
        wr(4'd0, k256[0], 1'b0, '0);
        chk_b("write_clears_ready", keys_ready, 1'b0);
        for (int i = 1; i < 15; i++) wr(4'(i), k256[i], 1'b0, '0);
        exp_done = 1'b1; rounds_total = 4'd14;
        tick();
        exp_done = 1'b0;
        chk_b("aes256_keys_ready", keys_ready, 1'b1);
        push_stream(1'b1, 14, 1'b1);
        run_acked(1'b1, 15);

        // Forward stream with backpressure at idx 3 and a write attempt mid-stream
        push_stream(1'b0, 14, 1'b1);
        do_start(1'b0);
        for (int k = 0; k < 15; k++) begin
            wait_valid();
            if (k == 3) begin
                for (int c = 0; c < 5; c++) begin
                    chk_b("bp_hold_valid", key_valid_o, 1'b1);
                    chk_k("bp_hold_key", key_o, k256[3]);
                    chk_i("bp_hold_idx", int'(key_idx_o), 3);
                    if (c == 1) begin
                        w_e = 1'b1; round_key_addr = 4'd5; round_key = '1;
                    end
                    tick();
                    if (c == 1) begin
                        chk_b("busy_wr_err", wr_err, 1'b1);
                        w_e = 1'b0;
                    end
                end
            end
            key_ack = 1'b1;
            tick();
            key_ack = 1'b0;
        end
        chk_b("bp_end_busy", busy, 1'b0);
        chk_i("bp_queue_left", exp_q.size(), 0);

        // Reset while idx 5 is presented
        push_stream(1'b0, 14, 1'b1);
        do_start(1'b0);
        for (int k = 0; k < 5; k++) ack_one();
        wait_valid();
        chk_i("midrst_at_idx", int'(key_idx_o), 5);
        exp_q.delete();
        reset = 1'b1;
        tick();
        chk_b("midrst_valid", key_valid_o, 1'b0);
        chk_b("midrst_keys_ready", keys_ready, 1'b0);
        chk_b("midrst_busy", busy, 1'b0);
        reset = 1'b0;
        tick();
        do_start(1'b0);
        chk_b("post_rst_start_err", start_err, 1'b1);
        chk_b("post_rst_busy", busy, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
